// File: rtl/ecb_pkg.sv
// Shared types and default sizes for the serial XOR ECB sequencer.
package ecb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ecb_state_t;

   localparam int ECB_W     = 8;
   localparam int ECB_CNT_W = 16;

endpackage

// File: rtl/ecb_bit_xor.sv
// Single-bit XOR cipher cell; the controller feeds it one block bit per cycle.
module ecb_bit_xor (
   input  logic k,
   input  logic din,
   output logic dout
);

   assign dout = din ^ k;

endmodule

// File: rtl/ecb_serial_ctrl.sv
// Serialises a W-bit block LSB first through one XOR bit cell and reassembles
// the result word behind a valid/ready output.
module ecb_serial_ctrl
   import ecb_pkg::*;
#(
   parameter int W     = ECB_W,
   parameter int CNT_W = ECB_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_load,
   input  logic [W-1:0]     key_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_mode,
   output logic             key_loaded,
   output logic             busy,
   output logic [CNT_W-1:0] blk_cnt,
   output logic             key_err
);

   localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

   ecb_state_t       state_q, state_d;
   logic [W-1:0]     key_q, key_d;
   logic             key_loaded_q, key_loaded_d;
   logic [W-1:0]     sreg_q, sreg_d;
   logic [W-1:0]     res_q, res_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             mode_q, mode_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
   logic             key_err_q, key_err_d;
   logic             obit;

   ecb_bit_xor u_bit_xor (
      .k    (key_q[idx_q]),
      .din  (sreg_q[0]),
      .dout (obit)
   );

   // key_load wins over a same-cycle block so the old key never pairs with it
   assign in_ready  = (state_q == IDLE) & key_loaded_q & ~key_load;
   assign out_valid = (state_q == DONE);

   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      key_loaded_d = key_loaded_q;
      sreg_d       = sreg_q;
      res_d        = res_q;
      idx_d        = idx_q;
      mode_d       = mode_q;
      blk_cnt_d    = blk_cnt_q;
      key_err_d    = key_err_q;

      case (state_q)
         IDLE: begin
            if (key_load) begin
               key_d        = key_in;
               key_loaded_d = 1'b1;
            end else if (in_valid && in_ready) begin
               sreg_d  = in_data;
               mode_d  = in_mode;
               idx_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // LSB goes out first, so entering at the MSB restores bit order after W shifts
            res_d  = {obit, res_q[W-1:1]};
            sreg_d = {1'b0, sreg_q[W-1:1]};
            idx_d  = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) state_d = DONE;
            if (key_load) key_err_d = 1'b1;
         end
         DONE: begin
            if (out_ready) begin
               blk_cnt_d = blk_cnt_q + CNT_W'(1);
               state_d   = IDLE;
            end
            if (key_load) key_err_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         key_q        <= '0;
         key_loaded_q <= 1'b0;
         sreg_q       <= '0;
         res_q        <= '0;
         idx_q        <= '0;
         mode_q       <= 1'b0;
         busy_q       <= 1'b0;
         blk_cnt_q    <= '0;
         key_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         key_loaded_q <= key_loaded_d;
         sreg_q       <= sreg_d;
         res_q        <= res_d;
         idx_q        <= idx_d;
         mode_q       <= mode_d;
         busy_q       <= busy_d;
         blk_cnt_q    <= blk_cnt_d;
         key_err_q    <= key_err_d;
      end
   end

   assign out_data   = res_q;
   assign out_mode   = mode_q;
   assign key_loaded = key_loaded_q;
   assign busy       = busy_q;
   assign blk_cnt    = blk_cnt_q;
   assign key_err    = key_err_q;

endmodule

// File: tb/tb_ecb_serial_ctrl.sv
// Scoreboard bench for ecb_serial_ctrl: expected XOR results are queued on input
// handshakes and compared when the controller presents its output.
module tb_ecb_serial_ctrl;

   localparam int W     = 8;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             key_load = 1'b0;
   logic [W-1:0]     key_in = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_data = '0;
   logic             in_mode = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [W-1:0]     out_data;
   logic             out_mode;
   logic             key_loaded;
   logic             busy;
   logic [CNT_W-1:0] blk_cnt;
   logic             key_err;

   always #5 clk = ~clk;

   ecb_serial_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_load   (key_load),
      .key_in     (key_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_mode    (in_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_mode   (out_mode),
      .key_loaded (key_loaded),
      .busy       (busy),
      .blk_cnt    (blk_cnt),
      .key_err    (key_err)
   );

   typedef struct packed {
      logic [W-1:0] d;
      logic         m;
   } exp_t;

   exp_t             sb[$];
   int               n_vec = 0;
   int               n_err = 0;
   logic [W-1:0]     key_model = '0;
   logic [CNT_W-1:0] cnt_model = '0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      key_load  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      key_in    = '0;
      in_data   = '0;
      in_mode   = 1'b0;
      sb.delete();
      cnt_model = '0;
      key_model = '0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic load_key(input logic [W-1:0] k);
      key_in   = k;
      key_load = 1'b1;
      tick();
      key_load  = 1'b0;
      key_model = k;
   endtask

   // Drives a block until in_ready is seen, queues its expected result, returns after the capture edge.
   task automatic drive_block(input logic [W-1:0] d, input logic m, output bit ok, output int nw);
      exp_t e;
      in_data  = d;
      in_mode  = m;
      in_valid = 1'b1;
      ok = 1'b0;
      nw = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            e.d = d ^ key_model;
            e.m = m;
            sb.push_back(e);
            ok = 1'b1;
            break;
         end
         nw++;
      end
      tick();
      in_valid = 1'b0;
      if (!ok) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      end
   endtask

   task automatic wait_out(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         n++;
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_vec++; n_err++;
         $display("FAIL out_timeout: out_valid stayed %b, required 1", out_valid);
      end
   endtask

   task automatic pop_exp(output exp_t e);
      e = '0;
      if (sb.size() == 0) begin
         n_vec++; n_err++;
         $display("FAIL scoreboard_empty: output seen with no queued expectation");
      end else begin
         e = sb.pop_front();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_vec++;
      if ({in_ready, out_valid, out_data, out_mode, key_loaded, busy, blk_cnt, key_err} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: rdy=%b vld=%b data=%h mode=%b kl=%b busy=%b cnt=%0d kerr=%b, required all 0",
                  in_ready, out_valid, out_data, out_mode, key_loaded, busy, blk_cnt, key_err);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_encrypt();
      bit ok; int nw; int n; exp_t e;
      load_key(8'hA5);
      drive_block(8'h3C, 1'b0, ok, nw);
      wait_out(n, ok);
      n_vec++;
      if (n !== W + 1) begin
         n_err++;
         $display("FAIL enc_latency: out_valid after %0d cycles, required %0d", n, W + 1);
      end
      pop_exp(e);
      n_vec++;
      if (out_data !== e.d || out_mode !== e.m) begin
         n_err++;
         $display("FAIL enc_data: data=%h mode=%b, required data=%h mode=%b", out_data, out_mode, e.d, e.m);
      end
      tick();
      cnt_model++;
      n_vec++;
      if (blk_cnt !== cnt_model || busy !== 1'b0) begin
         n_err++;
         $display("FAIL enc_count: blk_cnt=%0d busy=%b, required blk_cnt=%0d busy=0", blk_cnt, busy, cnt_model);
      end
   endtask

   task automatic test_decrypt_roundtrip();
      bit ok; int nw; int n; exp_t e;
      drive_block(8'h99, 1'b1, ok, nw);
      wait_out(n, ok);
      pop_exp(e);
      n_vec++;
      if (out_data !== e.d || out_mode !== e.m) begin
         n_err++;
         $display("FAIL dec_data: data=%h mode=%b, required data=%h mode=%b", out_data, out_mode, e.d, e.m);
      end
      tick();
      cnt_model++;
      n_vec++;
      if (blk_cnt !== cnt_model) begin
         n_err++;
         $display("FAIL dec_count: blk_cnt=%0d, required %0d", blk_cnt, cnt_model);
      end
   endtask

   task automatic test_backpressure();
      bit ok; int nw; int n; exp_t e;
      apply_reset();
      in_data  = 8'h55;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_vec++;
         if (in_ready !== 1'b0 || key_loaded !== 1'b0) begin
            n_err++;
            $display("FAIL nokey_ready_%0d: in_ready=%b key_loaded=%b, required 0/0", i, in_ready, key_loaded);
         end
         tick();
      end
      in_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL nokey_capture: busy=%b out_valid=%b, required 0/0", busy, out_valid);
      end
      load_key(8'hFF);
      out_ready = 1'b0;
      drive_block(8'h00, 1'b0, ok, nw);
      wait_out(n, ok);
      pop_exp(e);
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (out_valid !== 1'b1 || out_data !== e.d || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_%0d: vld=%b data=%h rdy=%b, required vld=1 data=%h rdy=0",
                     i, out_valid, out_data, in_ready, e.d);
         end
         @(posedge clk);
         #1;
         if (i == 4) out_ready = 1'b1;
         @(negedge clk);
      end
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== e.d) begin
         n_err++;
         $display("FAIL hold_release: vld=%b data=%h, required vld=1 data=%h", out_valid, out_data, e.d);
      end
      tick();
      cnt_model++;
      n_vec++;
      if (blk_cnt !== cnt_model || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL hold_handshake: blk_cnt=%0d vld=%b, required blk_cnt=%0d vld=0", blk_cnt, out_valid, cnt_model);
      end
   endtask

   task automatic test_key_during_shift();
      bit ok; int nw; int n; exp_t e;
      load_key(8'h0F);
      drive_block(8'hF0, 1'b0, ok, nw);
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL shift_busy: busy=%b, required 1", busy);
      end
      tick();
      tick();
      key_in   = 8'h00;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      n_vec++;
      if (key_err !== 1'b1) begin
         n_err++;
         $display("FAIL key_err_set: key_err=%b, required 1", key_err);
      end
      wait_out(n, ok);
      pop_exp(e);
      n_vec++;
      if (out_data !== e.d) begin
         n_err++;
         $display("FAIL keyshift_data: data=%h, required %h", out_data, e.d);
      end
      tick();
      cnt_model++;
      drive_block(8'h0F, 1'b0, ok, nw);
      wait_out(n, ok);
      pop_exp(e);
      n_vec++;
      if (out_data !== e.d || key_err !== 1'b1) begin
         n_err++;
         $display("FAIL key_kept: data=%h key_err=%b, required data=%h key_err=1", out_data, key_err, e.d);
      end
      tick();
      cnt_model++;
      n_vec++;
      if (blk_cnt !== cnt_model) begin
         n_err++;
         $display("FAIL keyshift_count: blk_cnt=%0d, required %0d", blk_cnt, cnt_model);
      end
   endtask

   task automatic test_reset_mid_shift();
      bit ok; int nw;
      drive_block(8'h12, 1'b0, ok, nw);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({in_ready, out_valid, out_data, out_mode, key_loaded, busy, blk_cnt, key_err} !== '0) begin
         n_err++;
         $display("FAIL async_reset: rdy=%b vld=%b data=%h mode=%b kl=%b busy=%b cnt=%0d kerr=%b, required all 0",
                  in_ready, out_valid, out_data, out_mode, key_loaded, busy, blk_cnt, key_err);
      end
      sb.delete();
      cnt_model = '0;
      key_model = '0;
      tick();
      tick();
      rst_n    = 1'b1;
      in_data  = 8'h34;
      in_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_vec++;
         if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_%0d: rdy=%b vld=%b busy=%b, required 0/0/0", i, in_ready, out_valid, busy);
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok; int nw; int n; exp_t e;
      logic [W-1:0] blocks [4];
      blocks[0] = 8'h11; blocks[1] = 8'h80; blocks[2] = 8'h7E; blocks[3] = 8'h01;
      load_key(8'h01);
      key_in   = 8'h3C;
      key_load = 1'b1;
      in_data  = blocks[0];
      in_mode  = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL keyload_priority: in_ready=%b, required 0", in_ready);
      end
      tick();
      key_load  = 1'b0;
      key_model = 8'h3C;
      for (int b = 0; b < 4; b++) begin
         drive_block(blocks[b], b[0], ok, nw);
         if (b == 0) begin
            n_vec++;
            if (nw !== 0) begin
               n_err++;
               $display("FAIL accept_next_cycle: accepted after %0d extra cycles, required 0", nw);
            end
         end
         wait_out(n, ok);
         pop_exp(e);
         n_vec++;
         if (out_data !== e.d || out_mode !== e.m) begin
            n_err++;
            $display("FAIL b2b_data_%0d: data=%h mode=%b, required data=%h mode=%b", b, out_data, out_mode, e.d, e.m);
         end
         tick();
         cnt_model++;
         n_vec++;
         if (blk_cnt !== cnt_model) begin
            n_err++;
            $display("FAIL b2b_count_%0d: blk_cnt=%0d, required %0d", b, blk_cnt, cnt_model);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_encrypt();
      test_decrypt_roundtrip();
      test_backpressure();
      test_key_during_shift();
      test_reset_mid_shift();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
